// File: rtl/serial_word_loader_pkg.sv
// ---------------------------------------------------------------------------
// serial_word_loader_pkg
//
// Shared definitions for the serial word loader slice:
//   state_t        : FSM state encoding (IDLE / SHIFT / PARITY)
//   DEFAULT_WIDTH  : default number of bits per assembled word
//   cnt_width()    : width of a counter able to hold 0..WIDTH
// ---------------------------------------------------------------------------
package serial_word_loader_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

    // The bit counter must represent every value from 0 up to WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_loader_if.sv
// ---------------------------------------------------------------------------
// serial_word_loader_if
//
// Bundles the serial input side and the parallel output side of the loader.
//   clear      : synchronous abort of the partial word   (master -> slave)
//   din        : serial data bit                          (master -> slave)
//   din_valid  : din qualifier                            (master -> slave)
//   word       : last completed word                      (slave -> master)
//   word_valid : one-cycle load strobe                    (slave -> master)
//   busy       : a partial word is held                   (slave -> master)
//   bit_cnt    : bits accepted into the current word      (slave -> master)
//   parity_err : parity failure pulse, only when SERIAL_WORD_LOADER_PARITY_EN
//                is defined                               (slave -> master)
// ---------------------------------------------------------------------------
interface serial_word_loader_if
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = cnt_width(WIDTH)
);

    logic             clear;
    logic             din;
    logic             din_valid;
    logic [WIDTH-1:0] word;
    logic             word_valid;
    logic             busy;
    logic [CNT_W-1:0] bit_cnt;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    logic             parity_err;
`endif

    modport master (
        output clear,
        output din,
        output din_valid,
        input  word,
        input  word_valid,
        input  busy,
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        input  parity_err,
`endif
        input  bit_cnt
    );

    modport slave (
        input  clear,
        input  din,
        input  din_valid,
        output word,
        output word_valid,
        output busy,
`ifdef SERIAL_WORD_LOADER_PARITY_EN
        output parity_err,
`endif
        output bit_cnt
    );

endinterface

// File: rtl/swl_bit_counter.sv
// ---------------------------------------------------------------------------
// swl_bit_counter
//
// Counts accepted serial bits of the current word.
//   clk   : system clock
//   reset : synchronous active-high reset
//   inc   : a bit is accepted this cycle
//   clr   : abort, return count to zero
//   count : bits accepted so far (0..WIDTH-1)
//   last  : the next accepted bit completes the word
// ---------------------------------------------------------------------------
module swl_bit_counter #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             last
);

    logic [CNT_W-1:0] r_count;

    // Count accepted bits; wrap to zero on the bit that completes the word
    // so a back-to-back bit in the strobe cycle is counted as bit 0.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            r_count <= '0;
        end else if (inc) begin
            if (last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

    assign last  = (r_count == CNT_W'(WIDTH - 1));
    assign count = r_count;

endmodule

// File: rtl/serial_word_loader.sv
// ---------------------------------------------------------------------------
// serial_word_loader (top)
//
// Serial-to-parallel front end: shifts in WIDTH bits LSB first under
// din_valid and presents the word with a one-cycle load strobe meant to
// drive a register enable.
//   clk   : system clock, all state on rising edge
//   reset : synchronous active-high reset
//   bus   : serial_word_loader_if.slave (clear, din, din_valid, word,
//           word_valid, busy, bit_cnt [, parity_err])
//
// Optional feature: define SERIAL_WORD_LOADER_PARITY_EN to require an extra
// even-parity bit after each word; failing words raise parity_err instead
// of word_valid.
// ---------------------------------------------------------------------------
module serial_word_loader
    import serial_word_loader_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    serial_word_loader_if.slave bus
);

    localparam int CNT_W = cnt_width(WIDTH);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_word;
    logic             r_word_valid;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    logic             r_parity_err;
`endif

    logic [WIDTH-1:0] w_shifted;
    logic             w_accept;
    logic             w_last;
    logic [CNT_W-1:0] w_count;

    // New bits enter at the MSB so that after WIDTH shifts the first bit
    // received sits at bit 0.
    assign w_shifted = {bus.din, r_shreg[WIDTH-1:1]};

    // Data bits are only counted outside the parity slot.
    assign w_accept = bus.din_valid && !bus.clear &&
                      ((r_state == IDLE) || (r_state == SHIFT));

    swl_bit_counter #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_bit_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (w_accept),
        .clr   (bus.clear),
        .count (w_count),
        .last  (w_last)
    );

    // Main FSM plus shift register and registered outputs. Strobes default
    // low every cycle so they last exactly one cycle; clear drops the
    // partial word but keeps the last completed word visible.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_word_valid <= 1'b0;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (bus.clear) begin
                r_state <= IDLE;
                r_shreg <= '0;
            end else if (bus.din_valid) begin
                case (r_state)
                    IDLE: begin
                        r_shreg <= w_shifted;
                        r_state <= SHIFT;
                    end
                    SHIFT: begin
                        r_shreg <= w_shifted;
                        if (w_last) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                            r_state      <= PARITY;
`else
                            r_word       <= w_shifted;
                            r_word_valid <= 1'b1;
                            r_state      <= IDLE;
`endif
                        end
                    end
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                    PARITY: begin
                        // The candidate word is complete in r_shreg; din is p.
                        if ((^r_shreg ^ bus.din) == 1'b0) begin
                            r_word       <= r_shreg;
                            r_word_valid <= 1'b1;
                        end else begin
                            r_parity_err <= 1'b1;
                        end
                        r_state <= IDLE;
                    end
`endif
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.word       = r_word;
    assign bus.word_valid = r_word_valid;
    assign bus.busy       = (r_state != IDLE);
    assign bus.bit_cnt    = w_count;
`ifdef SERIAL_WORD_LOADER_PARITY_EN
    assign bus.parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_serial_word_loader.sv
// ---------------------------------------------------------------------------
// tb_serial_word_loader
//
// Directed bench for serial_word_loader with WIDTH=4. A bit-accumulating
// model tracks the expected outputs and is compared every cycle; literal
// expectations pin the model on the listed scenarios. Covers the parity
// variant when SERIAL_WORD_LOADER_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_serial_word_loader;
    import serial_word_loader_pkg::*;

    localparam int WIDTH = 4;
    localparam int CNT_W = cnt_width(WIDTH);

    logic clk   = 1'b0;
    logic reset = 1'b1;

    serial_word_loader_if #(.WIDTH(WIDTH)) bus ();

    serial_word_loader #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors     = 0;
    int checks     = 0;
    int dutStrobes = 0;
    bit checkEn    = 1'b0;

    // Model state: bits are accumulated arithmetically into mAcc.
    int mCount  = 0;
    int mAcc    = 0;
    int mCand   = 0;
    int mWord   = 0;
    int mValid  = 0;
    int mErr    = 0;
    bit mParity = 1'b0;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, actual, expected);
        end
    endtask

    // Advance the model by one rising edge using the inputs just applied.
    task automatic modelStep(input logic r, input logic c, input logic v, input logic d);
        if (r) begin
            mCount = 0; mAcc = 0; mCand = 0; mWord = 0;
            mValid = 0; mErr = 0; mParity = 1'b0;
        end else begin
            mValid = 0;
            mErr   = 0;
            if (c) begin
                mCount = 0; mAcc = 0; mParity = 1'b0;
            end else if (v) begin
                if (mParity) begin
                    if ((($countones(mCand) + int'(d)) % 2) == 0) begin
                        mWord  = mCand;
                        mValid = 1;
                    end else begin
                        mErr = 1;
                    end
                    mParity = 1'b0;
                end else begin
                    mAcc   = mAcc + (int'(d) << mCount);
                    mCount = mCount + 1;
                    if (mCount == WIDTH) begin
`ifdef SERIAL_WORD_LOADER_PARITY_EN
                        mCand   = mAcc;
                        mParity = 1'b1;
`else
                        mWord  = mAcc;
                        mValid = 1;
`endif
                        mCount = 0;
                        mAcc   = 0;
                    end
                end
            end
        end
    endtask

    // Drive one cycle of inputs, step the model on the edge, and return on
    // the following falling edge.
    task automatic applyStimulus(input logic r, input logic c, input logic v, input logic d);
        reset         = r;
        bus.clear     = c;
        bus.din_valid = v;
        bus.din       = d;
        @(posedge clk);
        modelStep(r, c, v, d);
        checkEn = 1'b1;
        @(negedge clk);
    endtask

    task automatic sendBits(input logic [7:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, bits[i]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("word",       32'(bus.word),       32'(mWord));
            checkOutput("word_valid", 32'(bus.word_valid), 32'(mValid));
            checkOutput("busy",       32'(bus.busy),       32'((mCount != 0) || mParity));
            checkOutput("bit_cnt",    32'(bus.bit_cnt),    32'(mCount));
`ifdef SERIAL_WORD_LOADER_PARITY_EN
            checkOutput("parity_err", 32'(bus.parity_err), 32'(mErr));
`endif
            if (bus.word_valid === 1'b1) dutStrobes++;
        end
    end

    initial begin
        int base;
        bus.clear     = 1'b0;
        bus.din_valid = 1'b1;
        bus.din       = 1'b1;

        // Reset held two cycles with valid data present.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("reset_word", 32'(bus.word), 32'd0);
        checkOutput("reset_cnt",  32'(bus.bit_cnt), 32'd0);

`ifndef SERIAL_WORD_LOADER_PARITY_EN
        // 1,0,1,1 on consecutive cycles.
        base = dutStrobes;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("busy_after_bit1", 32'(bus.busy), 32'd1);
        sendBits(8'b0000_1101 >> 1, 3);
        checkOutput("strobe_after_bit4", 32'(bus.word_valid), 32'd1);
        checkOutput("word_1101", 32'(bus.word), 32'hD);
        idle(2);
        checkOutput("strobe_count_a", 32'(dutStrobes - base), 32'd1);

        // Same bits with gaps of 1..3 cycles.
        base = dutStrobes;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        idle(1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        idle(2);
        checkOutput("cnt_hold_gap", 32'(bus.bit_cnt), 32'd2);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        idle(3);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("word_gaps", 32'(bus.word), 32'hD);
        idle(2);
        checkOutput("strobe_count_gaps", 32'(dutStrobes - base), 32'd1);

        // Two bits, clear with valid, then 0,0,0,1.
        base = dutStrobes;
        sendBits(8'b0000_0011, 2);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
        checkOutput("cnt_after_clear", 32'(bus.bit_cnt), 32'd0);
        checkOutput("word_kept_clear", 32'(bus.word), 32'hD);
        sendBits(8'b0000_1000, 4);
        checkOutput("word_1000", 32'(bus.word), 32'h8);
        idle(2);
        checkOutput("strobe_count_clear", 32'(dutStrobes - base), 32'd1);

        // Back-to-back words without a bubble.
        base = dutStrobes;
        sendBits(8'b0000_1010, 4);
        checkOutput("word_A", 32'(bus.word), 32'hA);
        sendBits(8'b0000_0101, 4);
        checkOutput("word_5", 32'(bus.word), 32'h5);
        idle(2);
        checkOutput("strobe_count_b2b", 32'(dutStrobes - base), 32'd2);
`else
        // Bad parity first: word stays at its reset value.
        base = dutStrobes;
        sendBits(8'b0000_1101, 4);
        checkOutput("busy_in_parity", 32'(bus.busy), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("parity_err_pulse", 32'(bus.parity_err), 32'd1);
        checkOutput("word_unchanged", 32'(bus.word), 32'd0);
        idle(2);
        // Good parity.
        sendBits(8'b0000_1101, 4);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        checkOutput("word_parity_ok", 32'(bus.word), 32'hD);
        checkOutput("strobe_parity_ok", 32'(bus.word_valid), 32'd1);
        // Clear aborts the parity slot.
        sendBits(8'b0000_0011, 4);
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        checkOutput("busy_after_clear", 32'(bus.busy), 32'd0);
        idle(2);
        checkOutput("strobe_count_par", 32'(dutStrobes - base), 32'd1);
`endif

        // Reset mid-word: partial word lost, no strobe.
        base = dutStrobes;
        sendBits(8'b0000_0101, 3);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("busy_after_reset", 32'(bus.busy), 32'd0);
        idle(3);
        checkOutput("strobe_count_reset", 32'(dutStrobes - base), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_word_loader.md
Name: serial_word_loader

Overview:
- Serial-to-parallel front end for the enabled D flip-flop register bank (1/2/4-bit registers with clk, reset, enable, D, Q).
- Shifts in WIDTH serial bits, LSB first, under a valid qualifier.
- Presents the assembled word together with a one-cycle load strobe.
- The word drives the register's D bus; the strobe drives its enable.

Parameters:
- WIDTH, 4, bits per assembled word; legal range 2..16.
- CNT_W, $clog2(WIDTH+1), width of the internal bit counter; derived, never overridden.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort; discards the partial word.
- din  input  1  serial data bit.
- din_valid  input  1  din is sampled on every rising edge where this is 1.
- word  output  WIDTH  last completed word; held until the next completion.
- word_valid  output  1  one-cycle load strobe; feeds the register enable.
- busy  output  1  high while a partial word (1..WIDTH-1 bits) is held.
- bit_cnt  output  CNT_W  number of bits accepted into the current word.

Behaviour:
- Reset values: word=0, word_valid=0, busy=0, bit_cnt=0, shift register=0, state=IDLE.
- Priority at each edge: reset > clear > din_valid.
- States:
  - IDLE: bit_cnt=0.
  - SHIFT: 1 <= bit_cnt <= WIDTH-1.
  - PARITY: exists only with the optional feature.
- IDLE, din_valid=1: shreg <= {din, shreg[WIDTH-1:1]}, bit_cnt <= 1, go to SHIFT. For WIDTH=1 this is illegal; excluded by parameter range.
- SHIFT, din_valid=1 and bit_cnt<WIDTH-1: shift, bit_cnt+1.
- SHIFT, din_valid=1 and bit_cnt==WIDTH-1 (last bit):
  - word <= {din, shreg[WIDTH-1:1]}, word_valid <= 1, bit_cnt <= 0.
  - Next state IDLE, or PARITY with the feature enabled.
- din_valid=0: state, shreg and bit_cnt hold. Gaps of any length are allowed.
- Output timing:
  - word_valid is registered and high for exactly one cycle, the cycle after the edge that sampled the last bit.
  - word changes at that same edge and is never modified while word_valid=0.
- Back-to-back words: a valid bit in the cycle where word_valid=1 is accepted as bit 0 of the next word. No bubble; sustained throughput is one word per WIDTH cycles.
- busy is combinational: (state != IDLE).
- clear=1: shreg, bit_cnt and state return to reset values. word is retained. word_valid forced 0 on the next cycle. A din_valid in the same cycle is ignored.
- reset mid-word: the partial word is lost and no strobe is issued.

Optional Feature:
- Macro: SERIAL_WORD_LOADER_PARITY_EN.
- Defined:
  - After the WIDTH-th bit, the FSM enters PARITY and waits for one more valid bit p.
  - If ^word_candidate ^ p == 0 (even parity): word updates and word_valid pulses, both one cycle after p is sampled.
  - Otherwise: extra output parity_err (1 bit, reset 0) pulses for one cycle, word is unchanged and word_valid stays 0.
  - busy stays high in PARITY. clear and reset abort PARITY exactly as they abort SHIFT.
  - Throughput is one word per WIDTH+1 valid cycles.
- Undefined: no PARITY state, no parity_err port; behaviour as above.

Decomposition:
- Package serial_word_loader_pkg contains:
  - state enum: IDLE=2'd0, SHIFT=2'd1, PARITY=2'd2.
  - default WIDTH constant.
  - function for CNT_W.
- One natural sub-module: swl_bit_counter.
  - Inputs: inc, clr.
  - Output: count.
  - Output last = (count == WIDTH-1).
- The FSM and shift register stay in the top module.

Test Plan (WIDTH=4):
- Hold reset=1 for 2 cycles with din_valid=1 -> word=0, word_valid=0, busy=0, bit_cnt=0 throughout.
- din 1,0,1,1 on 4 consecutive valid cycles -> word=4'b1101, word_valid high for exactly 1 cycle after the 4th edge; busy high for cycles 2-4.
- Same bits with din_valid=0 gaps of 1-3 cycles between bits -> identical word=4'b1101, single strobe, bit_cnt holds during gaps.
- Two bits 1,1, then clear=1 with din_valid=1, then 0,0,0,1 -> single strobe, word=4'b1000; no strobe for the aborted word.
- Back-to-back 0,1,0,1 then 1,0,1,0 with no idle cycle -> strobes 4 cycles apart; word=4'hA then 4'h5.
- Parity (macro defined):
  - Bits 1,0,1,1 then p=1 -> word=4'b1101, strobe.
  - Bits 1,0,1,1 then p=0 -> parity_err pulse, word unchanged, no strobe.
